// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation encodings and controller states.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_XOR = 3'b010,
      OP_ADD = 3'b011,
      OP_SUB = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

endpackage : alu_pkg

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH steps after start.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;

   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         mcand_d  = {{WIDTH{1'b0}}, a};
         acc_d    = '0;
         mplier_d = b;
         cnt_d    = CNT_W'(WIDTH);
         busy_d   = 1'b1;
      end else if (busy_q) begin
         if (cnt_q != '0) begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
         end else begin
            // done is seen by the top for exactly this one cycle
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   assign done    = busy_q && (cnt_q == '0);
   assign product = acc_q;

endmodule : alu_mul_seq

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes: single-cycle logic/arith/shift ops and a
// multi-cycle multiply; results and flags are registered and held until consumed.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;
   logic               valid_q, valid_d;

   logic               accept;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;
   logic               alu_ovf;

   assign in_ready = rst_n && (state_q == ST_IDLE) && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      sum       = {1'b0, a} + {1'b0, b};
      diff      = {1'b0, a} - {1'b0, b};
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (op_e'(op))
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_ADD: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
            alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res   = diff[WIDTH-1:0];
            alu_carry = diff[WIDTH];
            alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         // shift amounts of WIDTH or more naturally yield zero
         OP_SHL: alu_res = a << b;
         OP_SHR: alu_res = a >> b;
         default: alu_res = '0;
      endcase
   end

   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      valid_d   = valid_q && !out_ready;
      mul_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (op_e'(op) == OP_MUL) begin
                  mul_start = 1'b1;
                  state_d   = ST_MUL;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  carry_d  = alu_carry;
                  ovf_d    = alu_ovf;
                  valid_d  = 1'b1;
               end
            end
         end
         ST_MUL: begin
            if (mul_done) begin
               result_d = mul_product[WIDTH-1:0];
               zero_d   = (mul_product[WIDTH-1:0] == '0);
               carry_d  = |mul_product[2*WIDTH-1:WIDTH];
               ovf_d    = 1'b0;
               valid_d  = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
      end
   end

   assign result    = result_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;
   assign out_valid = valid_q;

endmodule : seq_alu

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8) with hand-computed expected values.
module tb_seq_alu;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             ovf;
   logic             out_valid;
   logic             out_ready;

   int n_cmp = 0;
   int n_err = 0;

   seq_alu #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .op        (op),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .result    (result),
      .zero      (zero),
      .carry     (carry),
      .ovf       (ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
      op       = o;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      #1;
      check("ready_before_accept", in_ready, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [7:0] r, input logic z,
                            input logic c, input logic v);
      check({tag, ".valid"}, out_valid, 1);
      check({tag, ".result"}, result, r);
      check({tag, ".zero"}, zero, z);
      check({tag, ".carry"}, carry, c);
      check({tag, ".ovf"}, ovf, v);
      $display("txn %s: result=%02h zero=%0b carry=%0b ovf=%0b", tag, result, zero, carry, ovf);
   endtask

   initial begin
      rst_n     = 1'b0;
      a         = '0;
      b         = '0;
      op        = 3'b000;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst.valid", out_valid, 0);
      check("rst.result", result, 0);
      check("rst.zero", zero, 0);
      check("rst.carry", carry, 0);
      check("rst.ovf", ovf, 0);
      check("rst.in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      check("rst.release_ready", in_ready, 1);

      do_op(3'b011, 8'hFF, 8'h01);
      check_out("add_ff_01", 8'h00, 1, 1, 0);
      do_op(3'b011, 8'h7F, 8'h01);
      check_out("add_7f_01", 8'h80, 0, 0, 1);
      do_op(3'b100, 8'h80, 8'h01);
      check_out("sub_80_01", 8'h7F, 0, 0, 1);
      do_op(3'b100, 8'h00, 8'h01);
      check_out("sub_00_01", 8'hFF, 0, 1, 0);
      do_op(3'b110, 8'h80, 8'h07);
      check_out("shr_80_07", 8'h01, 0, 0, 0);

      do_op(3'b111, 8'h0F, 8'h11);
      for (int i = 0; i < 9; i++) begin
         check("mul1.busy_ready", in_ready, 0);
         check("mul1.busy_valid", out_valid, 0);
         tick();
      end
      check_out("mul_0f_11", 8'hFF, 0, 0, 0);

      do_op(3'b111, 8'h10, 8'h10);
      for (int i = 0; i < 9; i++) tick();
      check_out("mul_10_10", 8'h00, 1, 1, 0);

      tick();
      check("drain.valid", out_valid, 0);
      out_ready = 1'b0;
      do_op(3'b010, 8'hA5, 8'h3C);
      op       = 3'b001;
      a        = 8'hF0;
      b        = 8'h0F;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_out("xor_hold", 8'h99, 0, 0, 0);
         check("xor_hold.in_ready", in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check_out("or_f0_0f", 8'hFF, 0, 0, 0);
      do_op(3'b000, 8'hF0, 8'h3C);
      check_out("and_f0_3c", 8'h30, 0, 0, 0);
      do_op(3'b101, 8'h01, 8'h08);
      check_out("shl_01_08", 8'h00, 1, 0, 0);
      tick();

      do_op(3'b111, 8'h03, 8'h05);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      check("mulrst.valid", out_valid, 0);
      check("mulrst.result", result, 0);
      check("mulrst.in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      check("mulrst.release_ready", in_ready, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("mulrst.no_result", out_valid, 0);
      end
      do_op(3'b011, 8'h03, 8'h04);
      check_out("add_03_04", 8'h07, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_seq_alu

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..64).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 Port a  input  WIDTH  operand A, unsigned bits (signed interpretation only for the overflow flag).
REQ-005 Port b  input  WIDTH  operand B; also the shift amount for SHL/SHR.
REQ-006 Port op  input  3  operation select: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SHL, 110 SHR (logical), 111 MUL.
REQ-007 Port in_valid  input  1  a/b/op presented.
REQ-008 Port in_ready  output  1  block accepts operands this cycle.
REQ-009 Port result  output  WIDTH  registered result.
REQ-010 Port zero  output  1  result == 0.
REQ-011 Port carry  output  1  carry/borrow/multiply-overflow flag.
REQ-012 Port ovf  output  1  signed overflow flag.
REQ-013 Port out_valid  output  1  result and flags valid.
REQ-014 Port out_ready  input  1  consumer takes the result this cycle.

Function
REQ-015 Accept SHALL occur on a rising edge where in_valid && in_ready; a, b and op SHALL be captured only then.
REQ-016 in_ready SHALL be 1 iff rst_n is 1, the FSM is in IDLE, and (!out_valid || out_ready), so single-cycle ops sustain one result per cycle.
REQ-017 FSM states SHALL be IDLE and MUL; accepting op 111 moves IDLE->MUL, and every other op stays in IDLE.
REQ-018 Ops 000-110 SHALL assert out_valid on the edge after accept (latency 1) with result and flags registered.
REQ-019 ADD SHALL give result = (a+b) mod 2^WIDTH, carry = bit WIDTH of the sum, and ovf = signed overflow.
REQ-020 SUB SHALL give result = (a-b) mod 2^WIDTH, carry = borrow (a < b unsigned), and ovf = signed overflow.
REQ-021 SHL/SHR SHALL shift a by the unsigned value of b, giving result 0 when b >= WIDTH; carry and ovf SHALL be 0.
REQ-022 AND/OR/XOR SHALL be bitwise, with carry and ovf 0.
REQ-023 MUL SHALL use iterative shift-add, one partial product per cycle, and assert out_valid exactly WIDTH+1 edges after accept.
REQ-024 MUL SHALL give result = low WIDTH bits of a*b, carry = 1 iff the high WIDTH bits are nonzero, and ovf = 0; the FSM SHALL return to IDLE when out_valid rises.
REQ-025 zero SHALL equal (result == 0) for every op.
REQ-026 While out_valid && !out_ready, result, flags and out_valid SHALL hold stable.
REQ-027 out_valid SHALL clear on an edge with out_ready = 1, unless a new accept on the same edge loads a new result.

Reset
REQ-028 While rst_n = 0 at a rising edge, the FSM SHALL go to IDLE and result, zero, carry, ovf and out_valid SHALL go to 0.
REQ-029 Reset SHALL abort an in-progress MUL with no result produced; in_ready SHALL be 0 while rst_n = 0.

Structure
REQ-030 A shared package alu_pkg SHALL hold the op encodings (OP_AND..OP_MUL) and the FSM state type.
REQ-031 The multiplier SHALL be a sub-module alu_mul_seq (start, a, b, done, product[2*WIDTH-1:0]) instantiated once.

Verification (WIDTH=8)
REQ-032 ADD a=FF, b=01 -> result 00, zero=1, carry=1, ovf=0, with out_valid on the edge after accept.
REQ-033 SUB a=80, b=01 -> result 7F, carry=0, ovf=1; SUB a=00, b=01 -> result FF, carry=1.
REQ-034 MUL a=0F, b=11 -> result FF, carry=0, with out_valid 9 edges after accept and in_ready 0 throughout; MUL a=10, b=10 -> result 00, carry=1, zero=1.
REQ-035 Hold out_ready=0 for 5 cycles after an XOR result -> result and flags stable and in_ready=0; then back-to-back ops OR, AND, SHL b=08 (result 00) -> one result per cycle.
REQ-036 rst_n=0 on the 4th cycle of a MUL -> next edge out_valid=0, FSM in IDLE, in_ready=1 after release; the following ADD 03+04 -> 07.
